// File: rtl/score_event_sequencer_pkg.sv
// Shared defaults, event categories and helpers for score_event_sequencer.
package score_event_sequencer_pkg;

  localparam int unsigned MONSTER_AMOUNT_DEF  = 16;
  localparam int unsigned ASTEROID_AMOUNT_DEF = 4;
  localparam int unsigned PENDING_WIDTH_DEF   = 5;
  localparam int unsigned NUM_CAT             = 3;

  typedef enum logic [1:0] {
    EVT_MONSTER,
    EVT_BOSS,
    EVT_ASTEROID
  } score_event_cat;

  // Round-robin successor, wrapping ASTEROID back to MONSTER.
  function automatic score_event_cat next_cat(input score_event_cat cat);
    case (cat)
      EVT_MONSTER: return EVT_BOSS;
      EVT_BOSS:    return EVT_ASTEROID;
      default:     return EVT_MONSTER;
    endcase
  endfunction

endpackage

// File: rtl/score_event_sequencer_popcount.sv
// Combinational population count of a WIDTH-bit vector.
module score_event_sequencer_popcount #(
  parameter int unsigned WIDTH = 16,
  localparam int unsigned CntW = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [CntW-1:0]  count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + CntW'(vec[i]);
    end
  end

endmodule

// File: rtl/score_event_sequencer.sv
// Queues kill/explode pulses per category and re-emits them one per clock.
// Define SCORE_EVENT_PRIORITY_EN for fixed BOSS > MONSTER > ASTEROID grant order.
module score_event_sequencer
  import score_event_sequencer_pkg::*;
#(
  parameter int unsigned MONSTER_AMOUNT  = MONSTER_AMOUNT_DEF,
  parameter int unsigned ASTEROID_AMOUNT = ASTEROID_AMOUNT_DEF,
  parameter int unsigned PENDING_WIDTH   = PENDING_WIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic [MONSTER_AMOUNT-1:0]  monster_hit,
  input  logic                       boss_hit,
  input  logic [ASTEROID_AMOUNT-1:0] asteroid_hit,
  input  logic                       game_over,
  output logic                       monster_died_pulse,
  output logic                       boss_died_pulse,
  output logic                       asteroid_exploded_pulse,
  output logic                       events_pending,
  output logic                       overflow
);

  localparam int unsigned MonW = $clog2(MONSTER_AMOUNT + 1);
  localparam int unsigned AstW = $clog2(ASTEROID_AMOUNT + 1);
  localparam int unsigned SumW = PENDING_WIDTH + MonW;
  localparam logic [PENDING_WIDTH-1:0] PendMax = '1;

  logic [MonW-1:0] monster_pop;
  logic [AstW-1:0] asteroid_pop;

  logic [NUM_CAT-1:0][SumW-1:0]          add;
  logic [NUM_CAT-1:0][PENDING_WIDTH-1:0] cnt_q, cnt_d;
  logic [NUM_CAT-1:0]                    nonzero, grant;
  logic                                  overflow_q, overflow_d;

  score_event_sequencer_popcount #(
    .WIDTH (MONSTER_AMOUNT)
  ) u_monster_pop (
    .vec   (monster_hit),
    .count (monster_pop)
  );

  score_event_sequencer_popcount #(
    .WIDTH (ASTEROID_AMOUNT)
  ) u_asteroid_pop (
    .vec   (asteroid_hit),
    .count (asteroid_pop)
  );

  always_comb begin
    add               = '0;
    add[EVT_MONSTER]  = SumW'(monster_pop);
    add[EVT_BOSS]     = SumW'(boss_hit);
    add[EVT_ASTEROID] = SumW'(asteroid_pop);
    for (int i = 0; i < NUM_CAT; i++) begin
      nonzero[i] = |cnt_q[i];
    end
  end

`ifdef SCORE_EVENT_PRIORITY_EN
  always_comb begin
    grant = '0;
    if (nonzero[EVT_BOSS]) begin
      grant[EVT_BOSS] = 1'b1;
    end else if (nonzero[EVT_MONSTER]) begin
      grant[EVT_MONSTER] = 1'b1;
    end else if (nonzero[EVT_ASTEROID]) begin
      grant[EVT_ASTEROID] = 1'b1;
    end
  end
`else
  score_event_cat rr_q, rr_d;

  // Search starts at rr_q; the first non-zero counter wins and the pointer moves past it.
  always_comb begin
    int unsigned idx;
    grant = '0;
    rr_d  = rr_q;
    idx   = 0;
    for (int unsigned k = 0; k < NUM_CAT; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_CAT) idx = idx - NUM_CAT;
      if (grant == '0 && nonzero[idx]) begin
        grant[idx] = 1'b1;
        rr_d       = next_cat(score_event_cat'(idx[1:0]));
      end
    end
    if (game_over) rr_d = EVT_MONSTER;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rr_q <= EVT_MONSTER;
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

  // Grant never exceeds the counter it comes from, so the subtraction cannot wrap.
  always_comb begin
    logic [SumW-1:0] sum;
    cnt_d      = cnt_q;
    overflow_d = overflow_q;
    sum        = '0;
    for (int i = 0; i < NUM_CAT; i++) begin
      sum = SumW'(cnt_q[i]) + add[i] - SumW'(grant[i]);
      if (game_over) begin
        cnt_d[i] = '0;
      end else if (sum > SumW'(PendMax)) begin
        cnt_d[i]   = PendMax;
        overflow_d = 1'b1;
      end else begin
        cnt_d[i] = sum[PENDING_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign monster_died_pulse      = grant[EVT_MONSTER];
  assign boss_died_pulse         = grant[EVT_BOSS];
  assign asteroid_exploded_pulse = grant[EVT_ASTEROID];
  assign events_pending          = |nonzero;
  assign overflow                = overflow_q;

endmodule
